// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM state encoding,
// retry counter sizing and the single-bit excitation function.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_state_e;

  localparam int MAX_RETRY_DEFAULT = 1;
  localparam int RW = $clog2(MAX_RETRY_DEFAULT + 1);

  // A zero-width counter is not legal, so MAX_RETRY=0 still gets one bit.
  function automatic int retry_cnt_w(input int max_retry);
    return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
  endfunction

  // Returns {J,K}; bits already at the wanted value are left alone.
  function automatic logic [1:0] jk_excite(input logic cur, input logic want,
                                           input logic use_toggle);
    logic [1:0] jk;
    jk = 2'b00;
    if (!cur && want) begin
      jk = {1'b1, use_toggle};
    end else if (cur && !want) begin
      jk = {use_toggle, 1'b1};
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Command/status bundle between a write-request source and the JK excitation driver.
interface jk_excite_driver_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;

  modport master (
    output req_valid, req_data,
    input  req_ready, busy, done, err, err_mask
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, busy, done, err, err_mask
  );
endinterface

// File: rtl/jk_excite_vec.sv
// Combinational WIDTH-wide J/K excitation from the current Q word and the wanted word.
module jk_excite_vec
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] want_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j_o[i], k_o[i]} = jk_excite(cur_i[i], want_i[i], USE_TOGGLE);
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a JK flop bank towards a requested word, reads it back, retries, and flags errors.
//   state | meaning
//   IDLE  | j/k=0, ready for a request
//   DRIVE | registered j/k presented to the bank for one edge
//   CHECK | bank result visible on q_in; done, retry or error
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit USE_TOGGLE = 1'b0,
  parameter int MAX_RETRY  = MAX_RETRY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_excite_driver_if.slave cmd,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out
);

  localparam int CNT_W = (MAX_RETRY == MAX_RETRY_DEFAULT) ? RW : retry_cnt_w(MAX_RETRY);
  localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  logic [WIDTH-1:0] want, exc_j, exc_k;

  // On accept the excitation targets the incoming word; on retry the latched target.
  assign want = (state_q == IDLE) ? cmd.req_data : target_q;

  jk_excite_vec #(
    .WIDTH      (WIDTH),
    .USE_TOGGLE (USE_TOGGLE)
  ) u_exc (
    .cur_i  (q_in),
    .want_i (want),
    .j_o    (exc_j),
    .k_o    (exc_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      retry_q  <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mask_d   = mask_q;
    unique case (state_q)
      IDLE: begin
        if (cmd.req_valid) begin
          target_d = cmd.req_data;
          j_d      = exc_j;
          k_d      = exc_k;
          retry_d  = '0;
          mask_d   = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_in == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIM) begin
          j_d     = exc_j;
          k_d     = exc_k;
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          mask_d  = q_in ^ target_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd.req_ready = (state_q == IDLE);
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.err_mask  = mask_q;
  assign j_out         = j_q;
  assign k_out         = k_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench: two drivers (set/reset and toggle excitation) each wired to a 4-bit JK bank model.
module tb_jk_excite_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jk_excite_driver_if #(.WIDTH(4)) if0 ();
  jk_excite_driver_if #(.WIDTH(4)) if1 ();

  logic [3:0] j0, k0, j1, k1;
  logic [3:0] bq0 = 4'hF;
  logic [3:0] bq1 = 4'hF;
  logic [3:0] st0 = 4'h0;
  logic [3:0] st1 = 4'h0;

  jk_excite_driver #(.WIDTH(4), .USE_TOGGLE(1'b0), .MAX_RETRY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(if0), .q_in(bq0), .j_out(j0), .k_out(k0)
  );
  jk_excite_driver #(.WIDTH(4), .USE_TOGGLE(1'b1), .MAX_RETRY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(if1), .q_in(bq1), .j_out(j1), .k_out(k1)
  );

  // JK characteristic equation; stuck-at-1 bits are forced every edge.
  always_ff @(posedge clk) begin
    bq0 <= ((j0 & ~bq0) | (~k0 & bq0)) | st0;
    bq1 <= ((j1 & ~bq1) | (~k1 & bq1)) | st1;
  end

  logic       sel = 1'b0;
  logic [3:0] o_j, o_k, o_q, o_mask;
  logic       o_ready, o_busy, o_done, o_err;
  always_comb begin
    o_j     = sel ? j1 : j0;
    o_k     = sel ? k1 : k0;
    o_q     = sel ? bq1 : bq0;
    o_mask  = sel ? if1.err_mask : if0.err_mask;
    o_ready = sel ? if1.req_ready : if0.req_ready;
    o_busy  = sel ? if1.busy : if0.busy;
    o_done  = sel ? if1.done : if0.done;
    o_err   = sel ? if1.err : if0.err;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] mq [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit s, input logic v, input logic [3:0] d);
    if (s) begin
      if1.req_valid = v;
      if1.req_data  = d;
    end else begin
      if0.req_valid = v;
      if0.req_data  = d;
    end
  endtask

  // Set bits need J, cleared bits need K; toggle mode drives both on every changing bit.
  function automatic logic [7:0] exp_jk(input bit tog, input logic [3:0] q, input logic [3:0] t);
    logic [3:0] up, dn;
    up = ~q & t;
    dn = q & ~t;
    return tog ? {up | dn, up | dn} : {up, dn};
  endfunction

  task automatic do_write(input bit s, input logic [3:0] tgt, input logic [3:0] st,
                          input logic [3:0] ej, input logic [3:0] ek,
                          input logic [3:0] ej2, input logic [3:0] ek2,
                          input int elat, input bit eerr,
                          input logic [3:0] emask, input logic [3:0] eq, input string nm);
    logic [3:0] tj [8];
    logic [3:0] tk [8];
    logic       tdone [8];
    logic       terr [8];
    logic       trdy [8];
    int w, lat, npulse, nboth;
    logic kind_err;
    sel = s;
    if (s) st1 = st; else st0 = st;
    tick();
    w = 0;
    while (!o_ready && w < 10) begin
      tick();
      w++;
    end
    chk({nm, "/ready_pre"}, 32'(o_ready), 32'd1);
    chk({nm, "/q_pre"}, 32'(o_q), 32'(mq[s] | st));
    drive_req(s, 1'b1, tgt);
    tick();
    drive_req(s, 1'b0, 4'($urandom));
    for (int t = 0; t < 8; t++) begin
      tj[t] = o_j; tk[t] = o_k; tdone[t] = o_done; terr[t] = o_err; trdy[t] = o_ready;
      if (t < 7) tick();
    end
    lat = -1; npulse = 0; nboth = 0; kind_err = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (tdone[t] && terr[t]) nboth++;
      if (tdone[t] || terr[t]) begin
        npulse++;
        if (lat < 0) begin
          lat = t;
          kind_err = terr[t];
        end
      end
    end
    chk({nm, "/j_drive"}, 32'(tj[0]), 32'(ej));
    chk({nm, "/k_drive"}, 32'(tk[0]), 32'(ek));
    if (eerr) begin
      chk({nm, "/j_retry"}, 32'(tj[2]), 32'(ej2));
      chk({nm, "/k_retry"}, 32'(tk[2]), 32'(ek2));
    end
    chk({nm, "/latency"}, 32'(lat), 32'(elat));
    chk({nm, "/is_err"}, 32'(kind_err), 32'(eerr));
    chk({nm, "/pulses"}, 32'(npulse), 32'd1);
    chk({nm, "/done_and_err"}, 32'(nboth), 32'd0);
    chk({nm, "/ready_at_pulse"}, 32'(trdy[elat]), 32'd1);
    chk({nm, "/err_mask"}, 32'(o_mask), 32'(emask));
    chk({nm, "/q_post"}, 32'(o_q), 32'(eq));
    mq[s] = eq;
  endtask

  typedef struct {
    bit         s;
    logic [3:0] tgt, st, j, k, j2, k2;
    int         lat;
    bit         e;
    logic [3:0] mask, q;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ea, eb;
    logic [7:0] rdy_pat, done_pat;
    logic [3:0] rj [8];
    logic [3:0] rk [8];
    logic       rr [8];
    logic       rd [8];
    logic [3:0] a, b;
    logic [3:0] tgt, st, q0, after;
    bit         s;

    tbl[0] = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b1010};
    tbl[1] = '{1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b1010};
    tbl[2] = '{1'b1, 4'b1010, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b1010};
    tbl[3] = '{1'b1, 4'b0101, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b0101};
    tbl[4] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b1011, 4'b0000, 4'b0001, 4, 1'b1, 4'b0001, 4'b0001};
    tbl[5] = '{1'b1, 4'b0000, 4'b0010, 4'b0111, 4'b0111, 4'b0010, 4'b0010, 4, 1'b1, 4'b0010, 4'b0010};
    tbl[6] = '{1'b0, 4'b0110, 4'b0000, 4'b0110, 4'b0001, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b0110};
    tbl[7] = '{1'b1, 4'b1101, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 2, 1'b0, 4'b0000, 4'b1101};

    mq[0] = 4'hF;
    mq[1] = 4'hF;
    drive_req(1'b0, 1'b0, 4'h0);
    drive_req(1'b1, 1'b0, 4'h0);

    // Reset state of both instances
    #2;
    chk("rst/ready0", 32'(if0.req_ready), 32'd1);
    chk("rst/busy0", 32'(if0.busy), 32'd0);
    chk("rst/jk0", 32'({j0, k0}), 32'd0);
    chk("rst/flags0", 32'({if0.done, if0.err, if0.err_mask}), 32'd0);
    chk("rst/ready1", 32'(if1.req_ready), 32'd1);
    chk("rst/jk1", 32'({j1, k1}), 32'd0);
    chk("rst/flags1", 32'({if1.done, if1.err, if1.err_mask}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].s, tbl[i].tgt, tbl[i].st, tbl[i].j, tbl[i].k, tbl[i].j2, tbl[i].k2,
               tbl[i].lat, tbl[i].e, tbl[i].mask, tbl[i].q, $sformatf("vec%0d", i));
    end

    // Request held valid through a write: second word accepted only in the done cycle
    sel = 1'b0;
    a = 4'b1001;
    b = 4'b0011;
    ea = exp_jk(1'b0, mq[0], a);
    eb = exp_jk(1'b0, a, b);
    rdy_pat  = 8'b1110_0100;
    done_pat = 8'b0010_0100;
    drive_req(1'b0, 1'b1, a);
    tick();
    drive_req(1'b0, 1'b1, b);
    for (int t = 0; t < 8; t++) begin
      rj[t] = o_j; rk[t] = o_k; rr[t] = o_ready; rd[t] = o_done;
      if (t == 3) drive_req(1'b0, 1'b0, 4'h0);
      if (t < 7) tick();
    end
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("hold/ready_t%0d", t), 32'(rr[t]), 32'(rdy_pat[t]));
      chk($sformatf("hold/done_t%0d", t), 32'(rd[t]), 32'(done_pat[t]));
    end
    chk("hold/jk_first", 32'({rj[0], rk[0]}), 32'(ea));
    chk("hold/jk_check", 32'({rj[1], rk[1]}), 32'd0);
    chk("hold/jk_second", 32'({rj[3], rk[3]}), 32'(eb));
    chk("hold/q_post", 32'(o_q), 32'(b));
    mq[0] = b;

    // Reset during DRIVE aborts the write
    sel = 1'b0;
    a = ~mq[0];
    ea = exp_jk(1'b0, mq[0], a);
    drive_req(1'b0, 1'b1, a);
    tick();
    drive_req(1'b0, 1'b0, 4'h0);
    chk("abort/jk_drive", 32'({o_j, o_k}), 32'(ea));
    #1 rst_n = 1'b0;
    #1;
    chk("abort/jk_async", 32'({o_j, o_k}), 32'd0);
    for (int t = 0; t < 2; t++) begin
      tick();
      chk($sformatf("abort/flags_t%0d", t), 32'({o_done, o_err}), 32'd0);
      chk($sformatf("abort/ready_t%0d", t), 32'(o_ready), 32'd1);
    end
    rst_n = 1'b1;
    tick();
    chk("abort/ready_post", 32'(o_ready), 32'd1);
    chk("abort/busy_post", 32'(o_busy), 32'd0);
    chk("abort/q_held", 32'(o_q), 32'(mq[0]));

    // Randomized writes against the word-level model
    for (int n = 0; n < 30; n++) begin
      s   = 1'($urandom_range(0, 1));
      tgt = 4'($urandom);
      st  = 4'h0;
      if ($urandom_range(0, 3) == 0) st = 4'b0001 << $urandom_range(0, 3);
      q0    = mq[s] | st;
      after = tgt | st;
      ea = exp_jk(s, q0, tgt);
      eb = exp_jk(s, after, tgt);
      do_write(s, tgt, st, ea[7:4], ea[3:0], eb[7:4], eb[3:0],
               (after == tgt) ? 2 : 4, after != tgt, after ^ tgt, after,
               $sformatf("rnd%0d", n));
    end
    st0 = 4'h0;
    st1 = 4'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
